// File: rtl/grf_pkg.sv
// Shared widths and the MDU result entry for the GRF write-port arbiter.
package grf_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_W-1:0]  addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] pc;
    } grf_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order synchronous FIFO of MDU results waiting for an idle GRF write cycle.
module wb_fifo
    import grf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  grf_entry_t din,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output grf_entry_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    grf_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage carries no reset; occupancy is tracked only by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/grf_wport_arbiter.sv
// Shares the GRF write port between WB (priority) and buffered MDU results,
// and tracks registers whose MDU result has not yet reached the GRF.
module grf_wport_arbiter
    import grf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_we,
    input  logic [REG_W-1:0]  wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] wb_pc,
    input  logic              md_valid,
    output logic              md_ready,
    input  logic [REG_W-1:0]  md_addr,
    input  logic [DATA_W-1:0] md_data,
    input  logic [DATA_W-1:0] md_pc,
    input  logic              issue_valid,
    input  logic [REG_W-1:0]  issue_addr,
    input  logic [REG_W-1:0]  rd1_addr,
    input  logic [REG_W-1:0]  rd2_addr,
    output logic              rd1_busy,
    output logic              rd2_busy,
    output logic              grf_we,
    output logic [REG_W-1:0]  grf_waddr,
    output logic [DATA_W-1:0] grf_wdata,
    output logic [DATA_W-1:0] grf_wpc
);

    grf_entry_t  md_entry;
    grf_entry_t  head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        wb_own;
    logic        drain;
    logic        push;
    logic        pop;
    logic        drain_clr;
    logic [31:0] pend;
    logic [31:0] pend_nxt;

    assign md_entry = '{addr: md_addr, data: md_data, pc: md_pc};

    assign wb_own    = wb_we && (wb_addr != REG_ZERO);
    assign drain     = !wb_own && !fifo_empty;
    assign md_ready  = rst_n && !fifo_full;
    assign push      = md_valid && md_ready;
    assign pop       = rst_n && drain;
    assign drain_clr = pop && (head.addr != REG_ZERO);

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (md_entry),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    // WB passes straight through so the GRF sees no extra latency on the pipeline path.
    always_comb begin
        grf_we    = 1'b0;
        grf_waddr = '0;
        grf_wdata = '0;
        grf_wpc   = '0;
        if (rst_n) begin
            if (wb_own) begin
                grf_we    = 1'b1;
                grf_waddr = wb_addr;
                grf_wdata = wb_data;
                grf_wpc   = wb_pc;
            end else if (!fifo_empty) begin
                grf_we    = (head.addr != REG_ZERO);
                grf_waddr = head.addr;
                grf_wdata = head.data;
                grf_wpc   = head.pc;
            end
        end
    end

    // Set is applied after clear so a same-cycle re-issue keeps the register pending.
    always_comb begin
        pend_nxt = pend;
        if (drain_clr) begin
            pend_nxt[head.addr] = 1'b0;
        end
        if (issue_valid && (issue_addr != REG_ZERO)) begin
            pend_nxt[issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    assign rd1_busy = rst_n && pend[rd1_addr];
    assign rd2_busy = rst_n && pend[rd2_addr];

endmodule
